// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: address width and the 2-bit
// direction counter encodings.
package branch_predictor_pkg;

    localparam int BP_ADDR_WIDTH = 16;

    localparam logic [1:0] BP_SNT      = 2'b00;  // strong not-taken
    localparam logic [1:0] BP_WNT      = 2'b01;  // weak not-taken
    localparam logic [1:0] BP_WT       = 2'b10;  // weak taken
    localparam logic [1:0] BP_ST       = 2'b11;  // strong taken
    localparam logic [1:0] BP_CTR_INIT = BP_WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute-stage training and performance counter signals of the
// branch predictor. The slave modport is the predictor itself.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  take_branch;
    logic [ADDR_WIDTH-1:0] branch_predict;
    logic                  hit;

    logic                  update_valid;
    logic [ADDR_WIDTH-1:0] update_pc;
    logic                  update_taken;
    logic [ADDR_WIDTH-1:0] update_target;
    logic                  update_mispredict;

    logic [15:0]           branch_count;
    logic [15:0]           mispredict_count;

    modport slave (
        input  pc,
        output take_branch, branch_predict, hit,
        input  update_valid, update_pc, update_taken, update_target, update_mispredict,
        output branch_count, mispredict_count
    );

    modport master (
        output pc,
        input  take_branch, branch_predict, hit,
        output update_valid, update_pc, update_taken, update_target, update_mispredict,
        input  branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating up/down direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_next
);

    // Step toward strong taken / strong not-taken, holding at either end.
    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != BP_ST) o_ctr_next = i_ctr + 2'd1;
        end else begin
            if (i_ctr != BP_SNT) o_ctr_next = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Lookup is combinational on
// the fetch pc; training from execute is written at the clock edge, so a
// same-cycle lookup of the trained index sees the old contents.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int ENTRIES    = 16,
    parameter int IDX_BITS   = $clog2(ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predictor_if.slave      bp
);

    localparam int TAG_W = ADDR_WIDTH - IDX_BITS - 1;

    // Per-field register arrays so every entry clears on the async reset.
    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];

    logic [15:0]           r_branch_count;
    logic [15:0]           r_mispredict_count;

    logic [IDX_BITS-1:0]   w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_take;

    logic [IDX_BITS-1:0]   w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic [1:0]            w_ctr_next;

    // pc[0] is always zero for 2-byte aligned instructions, so skip it.
    assign w_lk_idx = bp.pc[IDX_BITS:1];
    assign w_lk_tag = bp.pc[ADDR_WIDTH-1:IDX_BITS+1];
    assign w_up_idx = bp.update_pc[IDX_BITS:1];
    assign w_up_tag = bp.update_pc[ADDR_WIDTH-1:IDX_BITS+1];

    // Fetch-side lookup from the stored table state.
    always_comb begin
        w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        w_lk_take = w_lk_hit && r_ctr[w_lk_idx][1];
    end

    assign bp.hit            = w_lk_hit;
    assign bp.take_branch    = w_lk_take;
    assign bp.branch_predict = w_lk_take ? r_target[w_lk_idx] : '0;

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    sat_counter2 u_sat_counter2 (
        .i_ctr      (r_ctr[w_up_idx]),
        .i_taken    (bp.update_taken),
        .o_ctr_next (w_ctr_next)
    );

    // Table training: adjust on hit, allocate on a taken miss, ignore a not-taken miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= BP_CTR_INIT;
            end
        end else if (bp.update_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
                if (bp.update_taken) r_target[w_up_idx] <= bp.update_target;
            end else if (bp.update_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.update_target;
                r_ctr[w_up_idx]    <= BP_WT;
            end
        end
    end

    // Saturating counts of resolved branches and mispredictions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bp.update_valid) begin
            if (r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'd1;
            if (bp.update_mispredict && (r_mispredict_count != 16'hFFFF))
                r_mispredict_count <= r_mispredict_count + 16'd1;
        end
    end

    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, feeding the program counter stage. Each cycle it looks up the current fetch `pc` and drives `take_branch` and `branch_predict` to the program counter in the same cycle. The execute stage sends resolved branch outcomes back to train the table. Two saturating performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: instruction address width, matching the codebase define.
- `ENTRIES`, default 16: BTB entries; must be a power of two, minimum 2.
- `IDX_BITS`, default log2(`ENTRIES`): index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `pc`  in  `ADDR_WIDTH`  current fetch address from the program counter.
- `take_branch`  out  1  predicted taken.
- `branch_predict`  out  `ADDR_WIDTH`  predicted target.
- `hit`  out  1  valid entry with matching tag.
- `update_valid`  in  1  resolved branch presented this cycle.
- `update_pc`  in  `ADDR_WIDTH`  address of the resolved branch.
- `update_taken`  in  1  actual direction.
- `update_target`  in  `ADDR_WIDTH`  actual taken target.
- `update_mispredict`  in  1  execute detected a misprediction (flush issued).
- `branch_count`  out  16  resolved branches, saturating.
- `mispredict_count`  out  16  mispredictions, saturating.

## Operation
Addressing:
- Instructions are 2-byte aligned, so `pc[0]` is ignored.
- index = `pc[IDX_BITS:1]`.
- tag = `pc[ADDR_WIDTH-1:IDX_BITS+1]`.

Entry contents: valid, tag, target (`ADDR_WIDTH` bits), ctr (2 bits).

Counter encoding:
- 00 strong not-taken
- 01 weak not-taken
- 10 weak taken
- 11 strong taken

Lookup (combinational from stored state):
- `hit` = valid & tag match.
- `take_branch` = `hit` & ctr[1].
- `branch_predict` = target when `take_branch` is 1, otherwise 0.

Update, when `update_valid`=1:
- On a hit at `update_pc`: ctr increments (taken) or decrements (not taken), saturating at 11 and 00.
  - If taken, target is overwritten with `update_target`.
- On a miss with taken=1: allocate the entry. Set valid=1, write tag and target, set ctr=10. Any previous occupant is replaced.
- On a miss with taken=0: no table change.
- `branch_count` increments, saturating at 16'hFFFF.
- `mispredict_count` increments if `update_mispredict`=1, saturating at 16'hFFFF.

`update_mispredict` without `update_valid` is ignored.

Reset state (asynchronous clear):
- All entries: valid=0, ctr=01, tag=0, target=0.
- Both counters are 0.
- The resulting outputs are `take_branch`=0, `branch_predict`=0, `hit`=0.

## Timing
- Lookup has zero latency: outputs follow `pc` combinationally within the same cycle.
- An update is written at the rising edge. It becomes visible to lookups from the next cycle.
- Update and lookup to the same index in the same cycle: the lookup returns the pre-update contents. No bypass.
- No stall input. The program counter ignores predictions while stalled, and holding `pc` yields stable outputs.
- Reset asserted mid-operation clears all state immediately, independent of `clk`. Updates presented during reset are dropped.
- Updates resume on the first rising edge after `reset` deasserts.

## Structure
- Shared defines header, added to the codebase define file:
  - `ADDR_WIDTH`
  - counter encodings `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`
  - counter reset value `BP_CTR_INIT` = 01
- Sub-module `sat_counter2`: 2-bit saturating up/down next-state logic. Inputs ctr and taken; output next ctr. Instantiated once on the update path.
- Storage is per-field register arrays (valid, tag, target, ctr), not an inferred RAM, so that reset can clear every entry asynchronously.

## Test plan
1. Reset, then pc=0x0040 → `hit`=0, `take_branch`=0, `branch_predict`=0; both counters 0.
2. Cold allocation: update pc=0x0040, taken=1, target=0x0100. Next cycle, pc=0x0040 → `hit`=1, `take_branch`=1, `branch_predict`=0x0100.
3. Counter saturation on the same pc:
   - After two more taken updates, ctr=11.
   - Then one not-taken update → still predicts taken (ctr=10).
   - A second not-taken update → `take_branch`=0, `hit`=1.
   - Two further not-taken updates → ctr stays 00.
4. Aliasing: with 16 entries, allocate 0x0040 then 0x0060, which share an index. Lookup of 0x0040 → `hit`=0 (tag mismatch). Lookup of 0x0060 → `hit`=1.
5. Same-cycle collision: pc=0x0080 while allocating 0x0080 taken → `hit`=0 that cycle, `hit`=1 the next cycle.
6. Counters:
   - 3 updates with `update_mispredict`=1 → `branch_count`=3, `mispredict_count`=3.
   - Force `branch_count` to 16'hFFFF, apply one more update → it holds 16'hFFFF.
   - Assert `reset` between clock edges → all outputs 0 immediately.
